// File: rtl/lsu_bus_adapter.sv
// Load/store adapter: turns an EX-stage memory request into a valid/ready bus
// transaction with lane alignment, load extension, error detection and timeout.
module lsu_bus_adapter #(
  parameter int ADDR_W      = 32,
  parameter int XLEN        = 32,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid_i,
  input  logic                  req_we_i,
  input  logic [ADDR_W-1:0]     req_addr_i,
  input  logic [XLEN-1:0]       req_wdata_i,
  input  logic [2:0]            req_size_i,
  output logic                  hold_o,
  output logic                  resp_valid_o,
  output logic [XLEN-1:0]       resp_rdata_o,
  output logic                  err_o,
  output logic                  bus_req_o,
  output logic                  bus_we_o,
  output logic [ADDR_W-1:0]     bus_addr_o,
  output logic [XLEN/8-1:0]     bus_be_o,
  output logic [XLEN-1:0]       bus_wdata_o,
  input  logic                  bus_ready_i,
  input  logic                  bus_rvalid_i,
  input  logic [XLEN-1:0]       bus_rdata_i
);

  localparam int LANES   = XLEN / 8;
  localparam int OFF_W   = $clog2(LANES);
  localparam int CNT_W   = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam int TO_LAST = (TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0;
  localparam bit TO_EN   = (TIMEOUT_CYC > 0);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT_R, S_DONE} state_e;

  function automatic logic size_legal(input logic [2:0] size);
    logic ok;
    case (size)
      3'b000, 3'b001, 3'b010, 3'b100, 3'b101: ok = 1'b1;
      3'b011, 3'b110:                         ok = (XLEN == 64);
      default:                                ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic misaligned(input logic [2:0] size, input logic [2:0] lo);
    logic m;
    case (size[1:0])
      2'b01:   m = lo[0];
      2'b10:   m = |lo[1:0];
      2'b11:   m = |lo;
      default: m = 1'b0;
    endcase
    return m;
  endfunction

  function automatic logic [LANES-1:0] byte_en(input logic [2:0] size, input logic [OFF_W-1:0] off);
    logic [LANES-1:0] be;
    case (size[1:0])
      2'b00:   be = LANES'(1'b1) << off;
      2'b01:   be = LANES'(2'b11) << off;
      2'b10:   be = LANES'(4'hF) << off;
      default: be = {LANES{1'b1}};
    endcase
    return be;
  endfunction

  // Store data is right-aligned; copying it into every lane lets the bus pick any lane by be.
  function automatic logic [XLEN-1:0] lane_replicate(input logic [2:0] size, input logic [XLEN-1:0] d);
    logic [XLEN-1:0] r;
    r = {XLEN{1'b0}};
    for (int i = 0; i < LANES; i++) begin
      case (size[1:0])
        2'b00:   r[8*i +: 8] = d[7:0];
        2'b01:   r[8*i +: 8] = d[8*(i%2) +: 8];
        2'b10:   r[8*i +: 8] = d[8*(i%4) +: 8];
        default: r[8*i +: 8] = d[8*i +: 8];
      endcase
    end
    return r;
  endfunction

  function automatic logic [XLEN-1:0] load_extract(input logic [2:0] size, input logic [OFF_W-1:0] off,
                                                   input logic [XLEN-1:0] rdata);
    logic [XLEN-1:0] sh;
    logic [XLEN-1:0] mask;
    logic            sign;
    sh = rdata >> {off, 3'b000};
    case (size[1:0])
      2'b00:   begin mask = XLEN'(8'hFF);         sign = sh[7];      end
      2'b01:   begin mask = XLEN'(16'hFFFF);      sign = sh[15];     end
      2'b10:   begin mask = XLEN'(32'hFFFF_FFFF); sign = sh[31];     end
      default: begin mask = {XLEN{1'b1}};         sign = sh[XLEN-1]; end
    endcase
    return (sh & mask) | ((~size[2] & sign) ? ~mask : {XLEN{1'b0}});
  endfunction

  state_e            state_q, state_d;
  logic              we_q, we_d;
  logic [2:0]        size_q, size_d;
  logic [OFF_W-1:0]  off_q, off_d;
  logic [ADDR_W-1:0] baddr_q, baddr_d;
  logic [LANES-1:0]  be_q, be_d;
  logic [XLEN-1:0]   bwdata_q, bwdata_d;
  logic              err_q, err_d;
  logic [XLEN-1:0]   rdata_q, rdata_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              timeout_s;
  logic [XLEN-1:0]   ext_s;

  assign timeout_s = TO_EN && (cnt_q == CNT_W'(TO_LAST));
  assign ext_s     = load_extract(size_q, off_q, bus_rdata_i);

  // Next-state and capture logic; completion beats timeout in the same cycle.
  always_comb begin
    state_d  = state_q;
    we_d     = we_q;
    size_d   = size_q;
    off_d    = off_q;
    baddr_d  = baddr_q;
    be_d     = be_q;
    bwdata_d = bwdata_q;
    err_d    = err_q;
    rdata_d  = rdata_q;
    cnt_d    = cnt_q + CNT_W'(1'b1);
    case (state_q)
      S_IDLE: begin
        cnt_d = {CNT_W{1'b0}};
        if (req_valid_i) begin
          we_d     = req_we_i;
          size_d   = req_size_i;
          off_d    = req_addr_i[OFF_W-1:0];
          baddr_d  = {req_addr_i[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
          be_d     = byte_en(req_size_i, req_addr_i[OFF_W-1:0]);
          bwdata_d = lane_replicate(req_size_i, req_wdata_i);
          rdata_d  = {XLEN{1'b0}};
          err_d    = ~size_legal(req_size_i) | misaligned(req_size_i, req_addr_i[2:0]);
          state_d  = (~size_legal(req_size_i) | misaligned(req_size_i, req_addr_i[2:0])) ? S_DONE : S_REQ;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_REQ: begin
        if (bus_ready_i && we_q) begin
          state_d = S_DONE;
        end else if (bus_ready_i && bus_rvalid_i) begin
          rdata_d = ext_s;
          state_d = S_DONE;
        end else if (timeout_s) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else if (bus_ready_i) begin
          state_d = S_WAIT_R;
        end else begin
          state_d = S_REQ;
        end
      end
      S_WAIT_R: begin
        if (bus_rvalid_i) begin
          rdata_d = ext_s;
          state_d = S_DONE;
        end else if (timeout_s) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          state_d = S_WAIT_R;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and captured-request registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      we_q     <= 1'b0;
      size_q   <= 3'b000;
      off_q    <= {OFF_W{1'b0}};
      baddr_q  <= {ADDR_W{1'b0}};
      be_q     <= {LANES{1'b0}};
      bwdata_q <= {XLEN{1'b0}};
      err_q    <= 1'b0;
      rdata_q  <= {XLEN{1'b0}};
      cnt_q    <= {CNT_W{1'b0}};
    end else begin
      state_q  <= state_d;
      we_q     <= we_d;
      size_q   <= size_d;
      off_q    <= off_d;
      baddr_q  <= baddr_d;
      be_q     <= be_d;
      bwdata_q <= bwdata_d;
      err_q    <= err_d;
      rdata_q  <= rdata_d;
      cnt_q    <= cnt_d;
    end
  end

  assign hold_o       = ((state_q == S_IDLE) && req_valid_i) || (state_q == S_REQ) || (state_q == S_WAIT_R);
  assign resp_valid_o = (state_q == S_DONE);
  assign err_o        = (state_q == S_DONE) && err_q;
  assign resp_rdata_o = (state_q == S_DONE) ? rdata_q : {XLEN{1'b0}};
  assign bus_req_o    = (state_q == S_REQ);
  assign bus_we_o     = (state_q == S_REQ) && we_q;
  assign bus_addr_o   = (state_q == S_REQ) ? baddr_q : {ADDR_W{1'b0}};
  assign bus_be_o     = (state_q == S_REQ) ? be_q : {LANES{1'b0}};
  assign bus_wdata_o  = (state_q == S_REQ) ? bwdata_q : {XLEN{1'b0}};

endmodule

// File: tb/tb_lsu_bus_adapter.sv
// Scoreboard bench for lsu_bus_adapter: one 32-bit and one 64-bit instance share
// the stimulus; a negedge monitor compares against a per-transaction reference.
module tb_lsu_bus_adapter;
  localparam int T = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        rst, sel, mon_en;
  logic        req_valid, req_we;
  logic [31:0] req_addr;
  logic [63:0] req_wdata;
  logic [2:0]  req_size;
  logic        bus_ready, bus_rvalid;
  logic [63:0] bus_rdata;

  logic        hold32, resp32, err32, breq32, bwe32;
  logic [31:0] rdata32, baddr32, bwd32;
  logic [3:0]  be32;
  logic        hold64, resp64, err64, breq64, bwe64;
  logic [63:0] rdata64, bwd64;
  logic [31:0] baddr64;
  logic [7:0]  be64;

  lsu_bus_adapter #(.ADDR_W(32), .XLEN(32), .TIMEOUT_CYC(T)) u32 (
    .clk(clk), .rst(rst), .req_valid_i(req_valid && !sel), .req_we_i(req_we),
    .req_addr_i(req_addr), .req_wdata_i(req_wdata[31:0]), .req_size_i(req_size),
    .hold_o(hold32), .resp_valid_o(resp32), .resp_rdata_o(rdata32), .err_o(err32),
    .bus_req_o(breq32), .bus_we_o(bwe32), .bus_addr_o(baddr32), .bus_be_o(be32),
    .bus_wdata_o(bwd32), .bus_ready_i(bus_ready), .bus_rvalid_i(bus_rvalid),
    .bus_rdata_i(bus_rdata[31:0]));

  lsu_bus_adapter #(.ADDR_W(32), .XLEN(64), .TIMEOUT_CYC(T)) u64 (
    .clk(clk), .rst(rst), .req_valid_i(req_valid && sel), .req_we_i(req_we),
    .req_addr_i(req_addr), .req_wdata_i(req_wdata), .req_size_i(req_size),
    .hold_o(hold64), .resp_valid_o(resp64), .resp_rdata_o(rdata64), .err_o(err64),
    .bus_req_o(breq64), .bus_we_o(bwe64), .bus_addr_o(baddr64), .bus_be_o(be64),
    .bus_wdata_o(bwd64), .bus_ready_i(bus_ready), .bus_rvalid_i(bus_rvalid),
    .bus_rdata_i(bus_rdata));

  logic        m_hold, m_resp, m_err, m_breq, m_we;
  logic [63:0] m_rdata, m_wdata;
  logic [31:0] m_addr;
  logic [7:0]  m_be;
  assign m_hold  = sel ? hold64 : hold32;
  assign m_resp  = sel ? resp64 : resp32;
  assign m_err   = sel ? err64  : err32;
  assign m_breq  = sel ? breq64 : breq32;
  assign m_we    = sel ? bwe64  : bwe32;
  assign m_rdata = sel ? rdata64 : {32'h0, rdata32};
  assign m_wdata = sel ? bwd64   : {32'h0, bwd32};
  assign m_addr  = sel ? baddr64 : baddr32;
  assign m_be    = sel ? be64    : {4'h0, be32};

  typedef struct {
    logic        err;
    logic [63:0] rdata;
    int          done_cyc;
    int          req_lo;
    int          req_hi;
    logic        we;
    logic [31:0] baddr;
    logic [7:0]  be;
    logic [63:0] bwd;
  } exp_t;
  exp_t sb[$];

  int nchk = 0;
  int nerr = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every cycle check hold/bus_req against the head entry, pop on responses.
  always @(negedge clk) begin
    if (mon_en) begin
      exp_t e;
      bit   have;
      have = (sb.size() > 0);
      if (have) e = sb[0];
      chk("hold", 64'(m_hold), 64'(have && (cyc != e.done_cyc)));
      chk("bus_req", 64'(m_breq), 64'(have && (cyc >= e.req_lo) && (cyc <= e.req_hi)));
      if (have && m_breq) begin
        chk("bus_we", 64'(m_we), 64'(e.we));
        chk("bus_addr", 64'(m_addr), 64'(e.baddr));
        chk("bus_be", 64'(m_be), 64'(e.be));
        if (e.we) chk("bus_wdata", m_wdata, e.bwd);
      end
      if (m_resp) begin
        if (!have) begin
          chk("unexpected_resp", 64'(m_resp), 64'(1'b0));
        end else begin
          chk("resp_cycle", 64'(cyc), 64'(e.done_cyc));
          chk("err", 64'(m_err), 64'(e.err));
          chk("rdata", m_rdata, e.rdata);
          void'(sb.pop_front());
        end
      end else if (have && cyc >= e.done_cyc) begin
        chk("missing_resp", 64'(m_resp), 64'(1'b1));
        void'(sb.pop_front());
      end
    end
  end

  // r: period (after REQ entry) in which ready is driven; rvalid comes d periods later.
  task automatic do_txn(input bit s, input bit we, input logic [31:0] addr, input logic [2:0] size,
                        input logic [63:0] wd, input logic [63:0] rd, input int r, input int d,
                        input int rst_k);
    exp_t        e;
    int          lanes, nb, off, c0, rv;
    bit          legal, ok;
    logic [63:0] rdm, sh, mask, val;
    lanes = s ? 8 : 4;
    nb    = 1 << size[1:0];
    off   = int'(addr % lanes);
    rv    = r + d;
    legal = (size inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) || (s && (size inside {3'd3, 3'd6}));
    c0    = cyc + 1;
    e.we    = we;
    e.baddr = addr & ~(lanes - 1);
    e.be    = 8'(((1 << nb) - 1) << off);
    e.bwd   = 64'h0;
    for (int i = 0; i < lanes; i++) e.bwd[8*i +: 8] = wd[8*(i % nb) +: 8];
    e.rdata = 64'h0;
    if (!legal || (addr % nb) != 0) begin
      e.err = 1'b1; e.done_cyc = c0; e.req_lo = 0; e.req_hi = -1;
    end else begin
      ok = we ? (r <= T - 1) : (rv <= T - 1);
      e.err      = !ok;
      e.done_cyc = ok ? (c0 + (we ? r : rv) + 1) : (c0 + T);
      e.req_lo   = c0;
      e.req_hi   = c0 + ((r < T - 1) ? r : T - 1);
      if (ok && !we) begin
        rdm  = s ? rd : {32'h0, rd[31:0]};
        sh   = rdm >> (8 * off);
        mask = (nb == 8) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'h1 << (8 * nb)) - 64'h1);
        val  = sh & mask;
        if (!size[2] && sh[8*nb-1]) val = val | ~mask;
        if (!s) val = val & 64'hFFFF_FFFF;
        e.rdata = val;
      end
    end
    sb.push_back(e);
    sel = s; req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wd; req_size = size;
    bus_ready = 1'b0; bus_rvalid = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      if (m_resp) req_valid = 1'b0;
      if (k == rst_k) begin
        rst = 1'b0; req_valid = 1'b0;
      end
      if (rst_k >= 0 && k == rst_k + 1) begin
        rst = 1'b1;
        sb.delete();
        chk("rst_ctrl", 64'({m_hold, m_resp, m_err, m_breq, m_we}), 64'h0);
        chk("rst_rdata", m_rdata, 64'h0);
        chk("rst_bus", 64'({m_addr, m_be}), 64'h0);
        chk("rst_wdata", m_wdata, 64'h0);
      end
      bus_ready  = (k == r);
      bus_rvalid = !we && (k == rv);
      bus_rdata  = (k == rv) ? rd : {$urandom, $urandom};
    end
    req_valid = 1'b0; bus_ready = 1'b0; bus_rvalid = 1'b0;
  endtask

  initial begin
    rst = 1'b0; sel = 1'b0; mon_en = 1'b0;
    req_valid = 1'b0; req_we = 1'b0; req_addr = 32'h0; req_wdata = 64'h0; req_size = 3'b000;
    bus_ready = 1'b0; bus_rvalid = 1'b0; bus_rdata = 64'h0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset32_ctrl", 64'({hold32, resp32, err32, breq32, bwe32, be32}), 64'h0);
    chk("reset32_data", {rdata32, baddr32 | bwd32}, 64'h0);
    chk("reset64_ctrl", 64'({hold64, resp64, err64, breq64, bwe64, be64}), 64'h0);
    chk("reset64_data", rdata64 | bwd64 | {32'h0, baddr64}, 64'h0);
    rst = 1'b1; mon_en = 1'b1;

    do_txn(1'b0, 1'b1, 32'h1003, 3'b000, 64'hA5, 64'h0, 0, 0, -1);               // SB
    do_txn(1'b0, 1'b0, 32'h2001, 3'b000, 64'h0, 64'h0000_8000, 0, 2, -1);        // LB
    do_txn(1'b0, 1'b0, 32'h2001, 3'b100, 64'h0, 64'h0000_8000, 0, 2, -1);        // LBU
    do_txn(1'b0, 1'b0, 32'h2002, 3'b010, 64'h0, 64'h1234_5678, 0, 0, -1);       // LW misaligned
    do_txn(1'b0, 1'b0, 32'h2000, 3'b011, 64'h0, 64'h1234_5678, 0, 0, -1);       // D on 32-bit
    do_txn(1'b0, 1'b1, 32'h3000, 3'b010, 64'h55AA, 64'h0, 20, 0, -1);           // no ready
    do_txn(1'b0, 1'b0, 32'h3008, 3'b010, 64'h0, 64'hDEAD_BEEF, 1, 6, -1);       // late rvalid
    do_txn(1'b0, 1'b0, 32'h0010, 3'b010, 64'h0, 64'h1111_2222, 0, 3, 1);        // reset in WAIT_R
    do_txn(1'b0, 1'b0, 32'h0010, 3'b010, 64'h0, 64'hCAFE_F00D, 1, 1, -1);
    do_txn(1'b1, 1'b0, 32'h0018, 3'b011, 64'h0, 64'h8000_0000_0000_0001, 0, 1, -1); // LD
    do_txn(1'b1, 1'b1, 32'h0024, 3'b001, 64'hBEEF, 64'h0, 2, 0, -1);            // SH on 64-bit

    for (int n = 0; n < 200; n++) begin
      do_txn(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom & 32'hFFFF,
             3'($urandom_range(0, 7)), {$urandom, $urandom}, {$urandom, $urandom},
             $urandom_range(0, 4), $urandom_range(0, 3), -1);
    end

    @(posedge clk); #1;
    chk("sb_drained", 64'(sb.size()), 64'h0);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
